// File: rtl/caravel_uart_pkg.sv
// Shared constants and FSM encoding for the Caravel UART boot harness.
package caravel_uart_pkg;

  localparam logic [7:0] FLASH_READ_CMD = 8'h03;
  localparam logic [7:0] TERMINATOR     = 8'h00;
  localparam logic [7:0] DONE_CODE      = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_READ = 3'd2,
    ST_TX   = 3'd3,
    ST_DONE = 3'd4
  } boot_state_e;

  // Full 32-bit READ command word: opcode followed by a 24-bit byte address.
  function automatic logic [31:0] read_cmd_word(input logic [23:0] addr);
    return {FLASH_READ_CMD, addr};
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: one start pulse launches a 10-bit frame of CLK_DIV clocks per bit.
module uart_tx_serializer #(
  parameter int CLK_DIV = 174
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] baud_r;
  logic [3:0]       bit_r;
  logic [8:0]       shift_r;
  logic             busy_r;
  logic             tx_r;

  // Frame shifter: start bit driven on the launch edge, then data LSB-first and stop bit
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      baud_r  <= '0;
      bit_r   <= 4'd0;
      shift_r <= 9'h1FF;
      busy_r  <= 1'b0;
      tx_r    <= 1'b1;
    end else if (start && !busy_r) begin
      baud_r  <= '0;
      bit_r   <= 4'd0;
      shift_r <= {1'b1, data};
      busy_r  <= 1'b1;
      tx_r    <= 1'b0;
    end else if (busy_r) begin
      if (baud_r == DIV_LAST) begin
        baud_r <= '0;
        if (bit_r == 4'd9) begin
          busy_r <= 1'b0;
          tx_r   <= 1'b1;
        end else begin
          bit_r   <= bit_r + 4'd1;
          tx_r    <= shift_r[0];
          shift_r <= {1'b1, shift_r[8:1]};
        end
      end else begin
        baud_r <= baud_r + DIV_W'(1);
      end
    end else begin
      tx_r <= 1'b1;
    end
  end

  assign busy = busy_r;
  assign tx   = tx_r;

endmodule

// File: rtl/caravel_uart_boot.sv
// Boots from SPI flash (READ @ 0) and streams bytes out of mprj_io[6] until 0x00 or MAX_LEN.
// Optional macro CHECKBITS_EN drives byte count / done code on mprj_io[31:16].
module caravel_uart_boot
  import caravel_uart_pkg::*;
#(
  parameter int CLK_DIV = 174,
  parameter int MAX_LEN = 256
) (
  input  logic        clock,
  input  logic        resetb,
  output logic        gpio,
  inout  wire  [37:0] mprj_io,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  localparam logic [31:0] CMD_WORD  = read_cmd_word(24'h000000);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  boot_state_e state_r;
  logic [2:0]  wait_r;
  logic [5:0]  bit_cnt_r;
  logic [31:0] cmd_sr_r;
  logic [7:0]  rx_sr_r;
  logic [15:0] count_r;
  logic        csb_r;
  logic        sck_r;
  logic        io0_r;
  logic        gpio_r;

  logic        byte_ready_s;
  logic        tx_start_s;
  logic        tx_busy_s;
  logic        tx_line_s;
  logic [15:0] count_next_s;

  // Frame launch coincides with the edge that lowers SCK after the eighth sample
  always_comb begin
    byte_ready_s = (bit_cnt_r == 6'd8);
    tx_start_s   = (state_r == ST_READ) && sck_r && byte_ready_s && (rx_sr_r != TERMINATOR);
    count_next_s = count_r + 16'd1;
  end

  uart_tx_serializer #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clock  (clock),
    .resetb (resetb),
    .start  (tx_start_s),
    .data   (rx_sr_r),
    .busy   (tx_busy_s),
    .tx     (tx_line_s)
  );

  // Boot sequencer: power-on wait, command shift, byte fetch, frame hand-off, completion
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_r   <= ST_IDLE;
      wait_r    <= 3'd0;
      bit_cnt_r <= 6'd0;
      cmd_sr_r  <= 32'h0000_0000;
      rx_sr_r   <= 8'h00;
      count_r   <= 16'h0000;
      csb_r     <= 1'b1;
      sck_r     <= 1'b0;
      io0_r     <= 1'b0;
      gpio_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wait_r == 3'd7) begin
            state_r   <= ST_CMD;
            csb_r     <= 1'b0;
            io0_r     <= CMD_WORD[31];
            cmd_sr_r  <= {CMD_WORD[30:0], 1'b0};
            bit_cnt_r <= 6'd0;
          end else begin
            wait_r <= wait_r + 3'd1;
          end
        end
        ST_CMD: begin
          if (!sck_r) begin
            sck_r     <= 1'b1;
            bit_cnt_r <= bit_cnt_r + 6'd1;
          end else begin
            sck_r <= 1'b0;
            if (bit_cnt_r == 6'd32) begin
              state_r   <= ST_READ;
              bit_cnt_r <= 6'd0;
              io0_r     <= 1'b0;
            end else begin
              io0_r    <= cmd_sr_r[31];
              cmd_sr_r <= {cmd_sr_r[30:0], 1'b0};
            end
          end
        end
        ST_READ: begin
          if (!sck_r) begin
            sck_r     <= 1'b1;
            rx_sr_r   <= {rx_sr_r[6:0], flash_io1};
            bit_cnt_r <= bit_cnt_r + 6'd1;
          end else begin
            sck_r <= 1'b0;
            if (byte_ready_s) begin
              bit_cnt_r <= 6'd0;
              if (rx_sr_r == TERMINATOR) begin
                state_r <= ST_DONE;
                csb_r   <= 1'b1;
                gpio_r  <= 1'b1;
              end else begin
                state_r <= ST_TX;
              end
            end
          end
        end
        ST_TX: begin
          // SCK stays parked low and CSB low while the frame drains
          if (!tx_busy_s) begin
            count_r <= count_next_s;
            if (count_next_s == MAX_LEN_W) begin
              state_r <= ST_DONE;
              csb_r   <= 1'b1;
              gpio_r  <= 1'b1;
            end else begin
              state_r <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          csb_r  <= 1'b1;
          gpio_r <= 1'b1;
          sck_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign gpio      = gpio_r;
  assign flash_csb = csb_r;
  assign flash_clk = sck_r;
  assign flash_io0 = io0_r;

  assign mprj_io[37:32] = {6{1'bz}};
  assign mprj_io[15:7]  = {9{1'bz}};
  assign mprj_io[6]     = tx_line_s;
  assign mprj_io[5:0]   = {6{1'bz}};

`ifdef CHECKBITS_EN
  logic [15:0] checkbits_r;

  // Status pads: done code in the upper byte, low byte of the transmitted count below
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      checkbits_r <= 16'h0000;
    end else begin
      checkbits_r <= {((state_r == ST_DONE) ? DONE_CODE : 8'h00), count_r[7:0]};
    end
  end

  assign mprj_io[31:16] = checkbits_r;
`else
  assign mprj_io[31:16] = {16{1'bz}};
`endif

endmodule

// File: tb/tb_caravel_uart_boot.sv
// Scoreboard bench: flash model feeds bytes, monitors decode SPI command, UART frames and gpio timing.
module tb_caravel_uart_boot;

  localparam int CLK_DIV = 8;
  localparam int MAX_LEN = 256;
  localparam int P       = 16 + 10 * CLK_DIV + 1;

  logic        clock  = 1'b0;
  logic        resetb = 1'b0;
  logic        gpio, flash_csb, flash_clk, flash_io0, flash_io1;
  wire  [37:0] mprj_io;
  logic        pad_dbg = 1'b0;

  assign mprj_io[5] = 1'b1;
  assign mprj_io[3] = 1'b1;
  assign mprj_io[0] = pad_dbg;

  caravel_uart_boot #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clock     (clock),
    .resetb    (resetb),
    .gpio      (gpio),
    .mprj_io   (mprj_io),
    .flash_csb (flash_csb),
    .flash_clk (flash_clk),
    .flash_io0 (flash_io0),
    .flash_io1 (flash_io1)
  );

  always #25 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] cmd_q[$];
  logic [7:0]  byte_q[$];
  int          gpio_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%h expected=nothing", name, act);
  endtask

  // Flash model: captures the command on SCK rise, shifts data out on SCK fall
  logic [7:0]  fl_mem [0:511];
  int          fl_cnt = 0;
  logic [31:0] fl_cmd = 32'h0;
  logic        fl_miso = 1'b0;
  assign flash_io1 = fl_miso;

  always @(posedge flash_clk or negedge flash_clk or posedge flash_csb) begin
    if (flash_csb) begin
      fl_cnt  = 0;
      fl_miso = 1'b0;
    end else if (flash_clk) begin
      if (fl_cnt < 32) fl_cmd = {fl_cmd[30:0], flash_io0};
      fl_cnt++;
      if (fl_cnt == 32) begin
        if (cmd_q.size() == 0) unexpected("spi_cmd_unexpected", fl_cmd);
        else check("spi_read_cmd", fl_cmd, cmd_q.pop_front());
      end
    end else if (fl_cnt >= 32) begin
      fl_miso = fl_mem[(fl_cnt - 32) / 8][7 - ((fl_cnt - 32) % 8)];
    end
  end

  // Ignored pad inputs wiggle throughout every run
  always @(negedge clock) pad_dbg <= 1'($urandom_range(0, 1));

  int cyc = 0;
  always @(posedge clock or negedge resetb) begin
    if (!resetb) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // UART monitor: samples each bit mid-cell and at its last cycle
  logic       in_frame = 1'b0;
  int         tick = 0;
  logic [9:0] mid_bits, end_bits;
  logic [7:0] exp_byte;
  initial begin
    forever begin
      @(negedge clock);
      if (!resetb) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (mprj_io[6] == 1'b0) begin
          in_frame = 1'b1;
          tick     = 0;
          mid_bits = '0;
          end_bits = '0;
        end
      end else begin
        tick++;
      end
      if (in_frame) begin
        if (tick % CLK_DIV == CLK_DIV / 2) mid_bits[tick / CLK_DIV] = mprj_io[6];
        if (tick % CLK_DIV == CLK_DIV - 1) begin
          end_bits[tick / CLK_DIV] = mprj_io[6];
          if (tick / CLK_DIV == 9) begin
            in_frame = 1'b0;
            if (byte_q.size() == 0) begin
              unexpected("uart_frame_unexpected", {22'h0, mid_bits});
            end else begin
              exp_byte = byte_q.pop_front();
              check("uart_frame", {22'h0, mid_bits}, {22'h0, 1'b1, exp_byte, 1'b0});
              check("uart_frame_cell_end", {22'h0, end_bits}, {22'h0, 1'b1, exp_byte, 1'b0});
            end
          end
        end
      end
    end
  end

  // gpio monitor: cycle of the rising edge counted from reset release
  logic gpio_prev = 1'b0;
  int   gpio_rises = 0;
  initial begin
    forever begin
      @(negedge clock);
      if (!resetb) begin
        gpio_prev = 1'b0;
      end else begin
        if (gpio && !gpio_prev) begin
          if (gpio_q.size() == 0) unexpected("gpio_rise_unexpected", cyc);
          else check("gpio_rise_cycle", cyc, gpio_q.pop_front());
          gpio_rises++;
        end
        gpio_prev = gpio;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clock);
    resetb = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic run_boot(input int budget);
    int base;
    base   = gpio_rises;
    resetb = 1'b1;
    for (int c = 0; c < budget && gpio_rises == base; c++) @(negedge clock);
    check("gpio_rise_seen", gpio_rises - base, 1);
    repeat (4) @(negedge clock);
    check("done_gpio", {31'h0, gpio}, 32'h1);
    check("done_csb", {31'h0, flash_csb}, 32'h1);
    check("done_tx_idle", {31'h0, mprj_io[6]}, 32'h1);
    check("frames_pending", byte_q.size(), 0);
    check("cmds_pending", cmd_q.size(), 0);
  endtask

  task automatic load_mem(input logic [7:0] fill);
    for (int i = 0; i < 512; i++) fl_mem[i] = fill;
  endtask

  initial begin
    apply_reset();
    check("rst_gpio", {31'h0, gpio}, 32'h0);
    check("rst_csb", {31'h0, flash_csb}, 32'h1);
    check("rst_sck", {31'h0, flash_clk}, 32'h0);
    check("rst_io0", {31'h0, flash_io0}, 32'h0);
    check("rst_tx", {31'h0, mprj_io[6]}, 32'h1);

    // "Hi\0"
    load_mem(8'h00);
    fl_mem[0] = 8'h48; fl_mem[1] = 8'h69; fl_mem[2] = 8'h00;
    cmd_q.push_back(32'h0300_0000);
    byte_q.push_back(8'h48); byte_q.push_back(8'h69);
    gpio_q.push_back(88 + 2 * P);
    run_boot(88 + 2 * P + 50);
`ifdef CHECKBITS_EN
    check("checkbits_hi", {16'h0, mprj_io[31:16]}, 32'h0000_A502);
`endif

    // Empty message: terminator first
    apply_reset();
    load_mem(8'h00);
    cmd_q.push_back(32'h0300_0000);
    gpio_q.push_back(88);
    run_boot(200);

    // Length cap: 300 bytes of 0x55 yield exactly MAX_LEN frames
    apply_reset();
    load_mem(8'h55);
    fl_mem[300] = 8'h00;
    cmd_q.push_back(32'h0300_0000);
    for (int i = 0; i < MAX_LEN; i++) byte_q.push_back(8'h55);
    gpio_q.push_back(88 + MAX_LEN * P - 16);
    run_boot(88 + MAX_LEN * P + 50);
`ifdef CHECKBITS_EN
    check("checkbits_max", {16'h0, mprj_io[31:16]}, 32'h0000_A500);
`endif

    // Reset in the middle of the second frame, then a clean restart from address 0
    apply_reset();
    load_mem(8'h00);
    fl_mem[0] = 8'h41; fl_mem[1] = 8'h42; fl_mem[2] = 8'h00;
    cmd_q.push_back(32'h0300_0000);
    byte_q.push_back(8'h41);
    resetb = 1'b1;
    repeat (88 + P + 5 * CLK_DIV) @(negedge clock);
    check("midframe_tx_low", {31'h0, mprj_io[6]}, {31'h0, 1'b0} | {31'h0, (8'h42 >> 3) & 8'h01});
    #7 resetb = 1'b0;
    #1;
    check("async_rst_tx", {31'h0, mprj_io[6]}, 32'h1);
    check("async_rst_csb", {31'h0, flash_csb}, 32'h1);
    check("async_rst_gpio", {31'h0, gpio}, 32'h0);
    check("async_rst_sck", {31'h0, flash_clk}, 32'h0);
    check("async_rst_io0", {31'h0, flash_io0}, 32'h0);
    repeat (3) @(negedge clock);
    cmd_q.push_back(32'h0300_0000);
    byte_q.push_back(8'h41); byte_q.push_back(8'h42);
    gpio_q.push_back(88 + 2 * P);
    run_boot(88 + 2 * P + 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/caravel_uart_boot.md
# caravel_uart_boot

Minimal Caravel-style harness that boots from an external SPI flash and streams a message out of the user-area UART pin. After reset it issues a standard READ command to the flash, fetches bytes sequentially, transmits each over UART 8N1 on `mprj_io[6]` until a 0x00 terminator or length limit, then raises `gpio` to signal completion. It sits at chip top, between the pad ring (`mprj_io`, flash pins, `gpio`) and the off-chip flash model.

## Interface
- `CLK_DIV`, 174: system clocks per UART bit (20 MHz / 115200).
- `MAX_LEN`, 256: maximum bytes transmitted before forced completion.
- `clock`  in  1  system clock, 20 MHz nominal (50 ns period).
- `resetb`  in  1  reset, asynchronous, active-low.
- `gpio`  out  1  completion flag.
- `mprj_io`  inout  38  user pads: [6] UART TX out, [5] UART RX in (unused), [3] housekeeping CSB in (ignored), [0] debug enable in (ignored), [31:16] checkbits out (see Configuration); all others high-Z.
- `flash_csb`  out  1  flash chip select, active-low.
- `flash_clk`  out  1  flash SCK, SPI mode 0.
- `flash_io0`  out  1  flash MOSI.
- `flash_io1`  in  1  flash MISO.

## Operation
- States: IDLE -> CMD -> READ -> TX -> (READ | DONE).
- IDLE: 8 cycles after `resetb` deasserts, drive `flash_csb` low, enter CMD.
- CMD: shift out 32 bits MSB-first: 0x03 then address 0x000000.
- READ: shift in 8 bits MSB-first from `flash_io1`. If byte == 0x00 -> DONE. Else -> TX.
- TX: send byte on `mprj_io[6]`: start bit 0, 8 data bits LSB-first, stop bit 1; each bit `CLK_DIV` cycles. Increment 16-bit byte count. If count == `MAX_LEN` -> DONE, else READ (next sequential byte; `flash_csb` stays low, SCK paused low).
- DONE: `flash_csb` high, `gpio` = 1, TX idle high; stays until reset.
- Terminator is never transmitted.
- Reset values: `gpio` 0, `flash_csb` 1, `flash_clk` 0, `flash_io0` 0, `mprj_io[6]` 1, byte count 0.
- `resetb` assertion at any point (mid-command, mid-byte, mid-frame) returns all outputs to reset values immediately; on release the sequence restarts from address 0.

## Timing
- SCK = clock/2: `flash_clk` toggles every cycle while shifting; `flash_io0` updates while SCK low, `flash_io1` sampled on the cycle SCK rises.
- CMD: 64 cycles; READ: 16 cycles per byte; SCK low between bytes.
- TX frame: 10 × `CLK_DIV` cycles; start bit begins the cycle after the last READ sample.
- `gpio` rises 1 cycle after terminator's last bit is sampled, or 1 cycle after the `MAX_LEN`th stop bit ends.
- `flash_csb` deasserts same cycle `gpio` rises.

## Configuration
- `CHECKBITS_EN` defined: `mprj_io[31:16]` driven; [23:16] = byte count low 8 bits, [31:24] = 0xA5 in DONE else 0x00; reset value 0x0000.
- Undefined: `mprj_io[31:16]` high-Z; no count/status register bits beyond internal count.

## Structure
- Package `caravel_uart_pkg`: state enum, `FLASH_READ_CMD` = 8'h03, `TERMINATOR` = 8'h00, `DONE_CODE` = 8'hA5.
- One sub-module: `uart_tx_serializer` (start pulse, 8-bit data, busy, tx line; `CLK_DIV` parameter).
- Top holds FSM, SPI shifter, byte counter, pad muxing.

## Test plan
- Flash "Hi\0" -> `flash_io0` shows 0x03000000 over first 32 SCK rises; TX frames 0x48 then 0x69, each 1740 cycles; `gpio` 1 after third byte read; checkbits 0xA502.
- First flash byte 0x00 -> no TX start bit; `gpio` 1 at cycle ~8+64+16+1 after reset release.
- 300 bytes of 0x55 -> exactly 256 frames, then `gpio` 1, `flash_csb` 1.
- Assert `resetb` mid-frame of second byte -> TX 1, `flash_csb` 1, `gpio` 0 immediately; release -> command re-issued at address 0.
- `mprj_io[5]` held 1, `mprj_io[3]`=1, `mprj_io[0]`=0 toggled randomly -> no effect on output stream.
- Build without `CHECKBITS_EN` -> `mprj_io[31:16]` reads Z throughout; TX stream identical.
